// File: rtl/cnn_layer_accel_weight_sequence_ctrl.sv
// Weight sequence table sequencer: walks a rows x cols tile, emitting C_SEQ_LEN address beats per position.
// Optional stall-cycle perf counter guarded by CNN_LAYER_ACCEL_WSEQ_PERF_CNT_EN.
module cnn_layer_accel_weight_sequence_ctrl #(
  parameter int C_ROW_W   = 10,
  parameter int C_COL_W   = 10,
  parameter int C_SEQ_LEN = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [C_ROW_W-1:0] cfg_num_rows,
  input  logic [C_COL_W-1:0] cfg_num_cols,
  input  logic               stall,
  output logic [1:0]         gray_code,
  output logic               sequence_selector,
  output logic [2:0]         seq_data_addr,
  output logic               seq_valid,
  output logic               wht_addr_valid,
  output logic               busy,
`ifdef CNN_LAYER_ACCEL_WSEQ_PERF_CNT_EN
  output logic               done,
  output logic [31:0]        stall_cycles
`else
  output logic               done
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [2:0] ADDR_LAST = 3'(C_SEQ_LEN - 1);

  // Row-phase code sequence 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] gray_step(input logic [1:0] g);
    case (g)
      2'b00:   gray_step = 2'b01;
      2'b01:   gray_step = 2'b11;
      2'b11:   gray_step = 2'b10;
      2'b10:   gray_step = 2'b00;
      default: gray_step = 2'b00;
    endcase
  endfunction

  state_t             state_r, state_nxt_s;
  logic [C_ROW_W-1:0] rows_r, rows_nxt_s, row_r, row_nxt_s;
  logic [C_COL_W-1:0] cols_r, cols_nxt_s, col_r, col_nxt_s;
  logic [2:0]         addr_r, addr_nxt_s;
  logic               sel_r, sel_nxt_s;
  logic [1:0]         gray_r, gray_nxt_s;
  logic               seq_valid_r, seq_valid_nxt_s;
  logic               wht_valid_r, wht_valid_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic               done_r, done_nxt_s;
  logic               last_beat_s;

  assign last_beat_s = (row_r == (rows_r - C_ROW_W'(1))) &&
                       (col_r == (cols_r - C_COL_W'(1))) &&
                       (addr_r == ADDR_LAST);

  // Next-state and next-output computation; position registers hold the last emitted beat
  always_comb begin
    state_nxt_s     = state_r;
    rows_nxt_s      = rows_r;
    cols_nxt_s      = cols_r;
    row_nxt_s       = row_r;
    col_nxt_s       = col_r;
    addr_nxt_s      = addr_r;
    sel_nxt_s       = sel_r;
    gray_nxt_s      = gray_r;
    seq_valid_nxt_s = 1'b0;
    wht_valid_nxt_s = seq_valid_r;

    if (abort && (state_r != ST_IDLE)) begin
      state_nxt_s     = ST_IDLE;
      row_nxt_s       = C_ROW_W'(0);
      col_nxt_s       = C_COL_W'(0);
      addr_nxt_s      = 3'd0;
      sel_nxt_s       = 1'b1;
      gray_nxt_s      = 2'b00;
      wht_valid_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !abort) begin
            rows_nxt_s = cfg_num_rows;
            cols_nxt_s = cfg_num_cols;
            row_nxt_s  = C_ROW_W'(0);
            col_nxt_s  = C_COL_W'(0);
            addr_nxt_s = 3'd0;
            sel_nxt_s  = 1'b1;
            gray_nxt_s = 2'b00;
            if ((cfg_num_rows == C_ROW_W'(0)) || (cfg_num_cols == C_COL_W'(0))) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s     = ST_RUN;
              seq_valid_nxt_s = 1'b1;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (last_beat_s) begin
            state_nxt_s = ST_DRAIN;
          end else if (stall) begin
            state_nxt_s = ST_RUN;
          end else begin
            seq_valid_nxt_s = 1'b1;
            if (addr_r == ADDR_LAST) begin
              addr_nxt_s = 3'd0;
              if (col_r == (cols_r - C_COL_W'(1))) begin
                col_nxt_s  = C_COL_W'(0);
                row_nxt_s  = row_r + C_ROW_W'(1);
                sel_nxt_s  = 1'b1;
                gray_nxt_s = gray_step(gray_r);
              end else begin
                col_nxt_s = col_r + C_COL_W'(1);
                sel_nxt_s = ~sel_r;
              end
            end else begin
              addr_nxt_s = addr_r + 3'd1;
            end
          end
        end
        ST_DRAIN: begin
          state_nxt_s = ST_DONE;
          row_nxt_s   = C_ROW_W'(0);
          col_nxt_s   = C_COL_W'(0);
          addr_nxt_s  = 3'd0;
          sel_nxt_s   = 1'b1;
          gray_nxt_s  = 2'b00;
        end
        ST_DONE: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          row_nxt_s   = C_ROW_W'(0);
          col_nxt_s   = C_COL_W'(0);
          addr_nxt_s  = 3'd0;
          sel_nxt_s   = 1'b1;
          gray_nxt_s  = 2'b00;
        end
      endcase
    end

    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // State, position and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rows_r      <= C_ROW_W'(0);
      cols_r      <= C_COL_W'(0);
      row_r       <= C_ROW_W'(0);
      col_r       <= C_COL_W'(0);
      addr_r      <= 3'd0;
      sel_r       <= 1'b1;
      gray_r      <= 2'b00;
      seq_valid_r <= 1'b0;
      wht_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rows_r      <= rows_nxt_s;
      cols_r      <= cols_nxt_s;
      row_r       <= row_nxt_s;
      col_r       <= col_nxt_s;
      addr_r      <= addr_nxt_s;
      sel_r       <= sel_nxt_s;
      gray_r      <= gray_nxt_s;
      seq_valid_r <= seq_valid_nxt_s;
      wht_valid_r <= wht_valid_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign gray_code         = gray_r;
  assign sequence_selector = sel_r;
  assign seq_data_addr     = addr_r;
  assign seq_valid         = seq_valid_r;
  assign wht_addr_valid    = wht_valid_r;
  assign busy              = busy_r;
  assign done              = done_r;

`ifdef CNN_LAYER_ACCEL_WSEQ_PERF_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of RUN cycles frozen by stall; cleared on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && start && !abort) begin
      stall_cnt_r <= 32'd0;
    end else if ((state_r == ST_RUN) && stall && !abort && !last_beat_s &&
                 (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequence_ctrl.sv
// Self-checking bench for cnn_layer_accel_weight_sequence_ctrl: table of tiles plus abort/reset sequences,
// beats checked against a scoreboard filled from an independent traversal model.
module tb_cnn_layer_accel_weight_sequence_ctrl;
  localparam int LEN = 5;

  typedef struct packed {
    logic [2:0] addr;
    logic       sel;
    logic [1:0] gray;
  } beat_t;

  typedef struct {
    int rows;
    int cols;
    int stall_beat;
    int stall_len;
    int restart_beat;
    int exp_beats;
    int exp_stall;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       stall = 1'b0;
  logic [9:0] cfg_num_rows = 10'd0;
  logic [9:0] cfg_num_cols = 10'd0;
  logic [1:0] gray_code;
  logic       sequence_selector;
  logic [2:0] seq_data_addr;
  logic       seq_valid;
  logic       wht_addr_valid;
  logic       busy;
  logic       done;
`ifdef CNN_LAYER_ACCEL_WSEQ_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  cnn_layer_accel_weight_sequence_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .cfg_num_rows      (cfg_num_rows),
    .cfg_num_cols      (cfg_num_cols),
    .stall             (stall),
    .gray_code         (gray_code),
    .sequence_selector (sequence_selector),
    .seq_data_addr     (seq_data_addr),
    .seq_valid         (seq_valid),
    .wht_addr_valid    (wht_addr_valid),
    .busy              (busy),
`ifdef CNN_LAYER_ACCEL_WSEQ_PERF_CNT_EN
    .done              (done),
    .stall_cycles      (stall_cycles)
`else
    .done              (done)
`endif
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    kill_q = 1'b1;
  logic  prev_valid = 1'b0;
  beat_t sb[$];
  beat_t mon_exp;
  beat_t mon_act;
  int    beats_seen = 0;
  int    first_beat_cyc = -1;
  int    last_beat_cyc = -1;
  int    done_count = 0;
  int    done_cyc = -1;
  int    start_cyc = 0;
  vec_t  vecs[7];
  logic [9:0] reset_vec;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    = cyc + 1;
    kill_q = rst | abort;
  end

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] pack_out();
    return {gray_code, sequence_selector, seq_data_addr, seq_valid, wht_addr_valid, busy, done};
  endfunction

  // Monitor: pops the scoreboard on every beat and tracks done pulses
  always @(negedge clk) begin
    if (!kill_q) check_eq("wht_delay", int'(wht_addr_valid), int'(prev_valid));
    if (seq_valid === 1'b1) begin
      mon_act = {seq_data_addr, sequence_selector, gray_code};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got beat 0x%0h, expected no beat (cycle %0d)", mon_act, cyc);
      end else begin
        mon_exp = sb.pop_front();
        check_eq("beat{addr,sel,gray}", int'(mon_act), int'(mon_exp));
      end
      if (beats_seen == 0) first_beat_cyc = cyc;
      beats_seen++;
      last_beat_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    prev_valid = seq_valid;
  end

  task automatic push_model(input int rows, input int cols);
    logic [1:0] gt [4];
    beat_t b;
    gt[0] = 2'b00; gt[1] = 2'b01; gt[2] = 2'b11; gt[3] = 2'b10;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        for (int a = 0; a < LEN; a++) begin
          b.addr = 3'(a);
          b.sel  = ((c % 2) == 0) ? 1'b1 : 1'b0;
          b.gray = gt[r % 4];
          sb.push_back(b);
        end
  endtask

  task automatic run_tile(input vec_t v);
    int base_done, budget, k;
    bit stalled, restarted;
    logic [2:0] hold;
    base_done = done_count;
    budget = v.exp_beats + v.stall_len + 12;
    k = 0; stalled = 1'b0; restarted = 1'b0;
    @(negedge clk); #1;
    beats_seen = 0; first_beat_cyc = -1; last_beat_cyc = -1;
    cfg_num_rows = 10'(v.rows);
    cfg_num_cols = 10'(v.cols);
    start = 1'b1;
    start_cyc = cyc;
    push_model(v.rows, v.cols);
    @(negedge clk); #1;
    start = 1'b0;
    cfg_num_rows = 10'd9;
    cfg_num_cols = 10'd9;
    while ((done_count == base_done) && (k < budget)) begin
      if ((v.stall_beat >= 0) && !stalled && (beats_seen == v.stall_beat + 1)) begin
        stalled = 1'b1;
        hold = 3'(v.stall_beat % LEN);
        stall = 1'b1;
        repeat (v.stall_len) begin
          @(negedge clk); #1;
          k++;
          check_eq("stall_hold{valid,addr}", int'({seq_valid, seq_data_addr}), int'({1'b0, hold}));
        end
        stall = 1'b0;
      end else if ((v.restart_beat >= 0) && !restarted && (beats_seen == v.restart_beat)) begin
        restarted = 1'b1;
        start = 1'b1;
        cfg_num_rows = 10'd7;
        cfg_num_cols = 10'd7;
        @(negedge clk); #1;
        k++;
        start = 1'b0;
        cfg_num_rows = 10'd9;
        cfg_num_cols = 10'd9;
      end else begin
        @(negedge clk); #1;
        k++;
      end
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
    end
    check_eq("done_count", done_count - base_done, 1);
    check_eq("busy_in_done", int'(busy), 1);
    if (v.exp_beats == 0) begin
      check_eq("zero_done_latency", done_cyc - start_cyc, 1);
    end else begin
      check_eq("first_beat_latency", first_beat_cyc - start_cyc, 1);
      check_eq("done_after_last_beat", done_cyc - last_beat_cyc, 2);
    end
    check_eq("beat_total", beats_seen, v.exp_beats);
    check_eq("scoreboard_left", sb.size(), 0);
`ifdef CNN_LAYER_ACCEL_WSEQ_PERF_CNT_EN
    check_eq("stall_cycles", int'(stall_cycles), v.exp_stall);
`endif
    @(negedge clk); #1;
    check_eq("idle_after_done{busy,done}", int'({busy, done}), 0);
  endtask

  task automatic abort_test(input bit use_rst);
    int base_done, k;
    base_done = done_count;
    k = 0;
    @(negedge clk); #1;
    beats_seen = 0;
    cfg_num_rows = 10'd3;
    cfg_num_cols = 10'd3;
    start = 1'b1;
    push_model(3, 3);
    @(negedge clk); #1;
    start = 1'b0;
    while ((beats_seen < 7) && (k < 30)) begin
      @(negedge clk); #1;
      k++;
    end
    check_eq(use_rst ? "rst_reach_beat7" : "abort_reach_beat7", beats_seen, 7);
    if (use_rst) rst = 1'b1;
    else abort = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    abort = 1'b0;
    check_eq(use_rst ? "rst_outputs" : "abort_outputs", int'(pack_out()), int'(reset_vec));
    sb.delete();
    repeat (5) @(negedge clk);
    #1;
    check_eq(use_rst ? "rst_no_done" : "abort_no_done", done_count - base_done, 0);
    check_eq(use_rst ? "rst_stays_idle" : "abort_stays_idle", int'({busy, seq_valid}), 0);
  endtask

  initial begin
    reset_vec = {2'b00, 1'b1, 3'b000, 4'b0000};
    //         rows cols stall_beat stall_len restart exp_beats exp_stall
    vecs[0] = '{2, 2, -1, 0, -1, 20, 0};
    vecs[1] = '{5, 1, -1, 0, -1, 25, 0};
    vecs[2] = '{1, 1,  2, 3, -1,  5, 3};
    vecs[3] = '{3, 0, -1, 0, -1,  0, 0};
    vecs[4] = '{0, 4, -1, 0, -1,  0, 0};
    vecs[5] = '{2, 3, -1, 0,  4, 30, 0};
    vecs[6] = '{3, 3, 11, 2, -1, 45, 2};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_outputs", int'(pack_out()), int'(reset_vec));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_tile(vecs[i]);

    abort_test(1'b0);
    abort_test(1'b1);
    run_tile('{3, 3, -1, 0, -1, 45, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cnn_layer_accel_weight_sequence_ctrl.md
# cnn_layer_accel_weight_sequence_ctrl

Sequencing controller for the convolution-engine weight sequence table. It walks a configured output tile row by row and column by column. For every output position it emits one 5-entry run of `seq_data_addr`, together with the `gray_code` and `sequence_selector` values that pick the table's sequence bank. It sits between the layer-level control FSM (`start`/`done`) and the weight sequence table. It also produces a valid strobe re-timed to the table's 1-cycle registered output.

## Interface
Parameters:
- `C_ROW_W`, 10, width of the row count.
- `C_COL_W`, 10, width of the column count.
- `C_SEQ_LEN`, 5, entries per sequence run (addresses 0..C_SEQ_LEN-1, max 8).

Ports:
- `clk`  in  1  the single clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  pulse; latches the configuration and begins a tile; honoured only in IDLE.
- `abort`  in  1  returns to IDLE without pulsing `done`.
- `cfg_num_rows`  in  C_ROW_W  number of output rows in the tile.
- `cfg_num_cols`  in  C_COL_W  number of output columns in the tile.
- `stall`  in  1  downstream back-pressure; freezes the sequence.
- `gray_code`  out  2  row-phase code sent to the table.
- `sequence_selector`  out  1  column-parity select sent to the table.
- `seq_data_addr`  out  3  table entry index.
- `seq_valid`  out  1  the current address triple is a real beat.
- `wht_addr_valid`  out  1  `seq_valid` delayed 1 cycle; qualifies the table's `wht_data_addr`.
- `busy`  out  1  high in RUN, DRAIN and DONE.
- `done`  out  1  single-cycle completion pulse.
- `stall_cycles`  out  32  present only with `CNN_LAYER_ACCEL_WSEQ_PERF_CNT_EN`.

## Operation
States:
- **IDLE**
  - `start` with either count equal to 0 → DONE, with no beats emitted.
  - `start` otherwise → RUN; the counts are latched and the counters cleared.
- **RUN**
  - On each cycle with `stall`=0: `seq_valid`=1 and `seq_data_addr` advances.
  - When `seq_data_addr` reaches C_SEQ_LEN-1 it wraps to 0 and `sequence_selector` toggles (column advance); `col_cnt` increments.
  - When `col_cnt` reaches cols-1: `col_cnt` goes to 0, `row_cnt` increments, `sequence_selector` reloads to 1, and `gray_code` steps 00→01→11→10→00.
  - On the last beat (row=rows-1, col=cols-1, addr=C_SEQ_LEN-1) → DRAIN.
- **DRAIN**: one cycle; `seq_valid`=0 and `wht_addr_valid` carries the final beat. Next state is DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.

Rules:
- `stall`=1 in RUN: all counters and outputs hold, and `seq_valid`=0. A stall never drops or repeats a beat.
- `abort` takes effect in any state other than IDLE: next cycle is IDLE, counters are cleared, and `done` is not pulsed. `abort` has priority over `start` and `stall`.
- `start` while `busy` is ignored. The configuration inputs are not sampled after the latch.
- Total beats per tile = rows × cols × C_SEQ_LEN.
- All counters are unsigned and wrap-free, bounded by the latched counts.

## Timing
- Reset values (next edge with `rst`=1):
  - `gray_code`=00, `sequence_selector`=1, `seq_data_addr`=0.
  - `seq_valid`=0, `wht_addr_valid`=0, `busy`=0, `done`=0, `stall_cycles`=0.
  - State is IDLE.
- `rst` mid-tile aborts immediately; no `done`.
- `start` is sampled at edge T. RUN starts at T+1 and the first beat (`seq_valid`=1, addr 0) is at T+1.
- `wht_addr_valid` equals `seq_valid` from the previous cycle, matching the table's registered `wht_data_addr`.
- If the last beat is at cycle N: DRAIN is at N+1, `done` at N+2, IDLE at N+3. A new `start` is accepted at N+3.
- Zero-size start at T: `done` at T+1, and no `seq_valid`.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `CNN_LAYER_ACCEL_WSEQ_PERF_CNT_EN` defined:
  - The `stall_cycles` port exists.
  - It counts cycles in RUN with `stall`=1 and saturates at 2^32-1.
  - It is cleared when a `start` is accepted, held in all other states, and readable after `done`.
- Not defined: the port and counter are absent. Sequencing behaviour is identical either way.

## Test plan
- **Basic tile:** rows=2, cols=2, no stall.
  - Expect 20 beats.
  - Row 0: addr 0..4 with sel=1, then 0..4 with sel=0; `gray_code`=00.
  - Row 1: same addr/sel pattern with `gray_code`=01.
  - `done` arrives 2 cycles after the last beat.
- **Gray wrap:** rows=5, cols=1.
  - `gray_code` per row is 00,01,11,10,00.
  - `sequence_selector` stays 1 throughout.
  - 25 beats.
- **Stall:** rows=1, cols=1; assert `stall` for 3 cycles while addr=2.
  - Addr holds at 2 and `seq_valid`=0 for 3 cycles.
  - Addresses resume 3,4; exactly 5 beats total.
  - With the macro, `stall_cycles`=3.
- **Zero size:** `start` with cols=0.
  - `done` at T+1; `seq_valid` never asserts; `busy` high for 1 cycle.
- **Abort/reset mid-op:** rows=3, cols=3.
  - `abort` at beat 7: IDLE next cycle, all outputs at their reset values, no `done`.
  - Repeat using `rst`: same result.
  - A following `start` runs the full 45 beats.
- **Start while busy:** pulse `start` with new counts during RUN.
  - Ignored; the tile completes with the originally latched counts and exactly one `done`.
